// File: rtl/dmem_pkg.sv
// Shared types and default widths for the data-memory write buffer.
package dmem_pkg;
    localparam int unsigned DMEM_ADDR_W = 16;
    localparam int unsigned DMEM_DATA_W = 16;
    localparam int unsigned DMEM_DEPTH  = 4;

    typedef struct packed {
        logic                   valid;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] data;
    } wbuf_entry_t;
endpackage

// File: rtl/wbuf_match.sv
// Parallel compare of one address against every buffer entry; valid entries hold
// unique addresses, so at most one bit of hit_vec is set.
module wbuf_match #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0]             addr,
    input  logic [DEPTH-1:0]              valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr,
    output logic                          hit,
    output logic [DEPTH-1:0]              hit_vec,
    output logic [IDX_W-1:0]              hit_idx
);
    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign hit_vec[i] = valid[i] && (entry_addr[i] == addr);
    end

    assign hit = |hit_vec;

    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_idx = hit_idx | (IDX_W'(i) & {IDX_W{hit_vec[i]}});
        end
    end
endmodule

// File: rtl/dmem_write_buffer.sv
// Posted-store buffer in front of dmemory: absorbs stores, forwards loads that hit,
// and retires entries in FIFO order whenever no load miss needs the memory port.
module dmem_write_buffer
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH  = DMEM_DEPTH,
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              buf_empty,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wbuf_entry_t      entries_q [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;

    logic [DEPTH-1:0]             valid_vec;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_vec;
    logic                         hit;
    logic [DEPTH-1:0]             hit_vec;
    logic [PTR_W-1:0]             hit_idx;

    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
        assign valid_vec[i] = entries_q[i].valid;
        assign addr_vec[i]  = entries_q[i].addr;
    end

    wbuf_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .IDX_W  (PTR_W)
    ) u_match (
        .addr       (cpu_addr),
        .valid      (valid_vec),
        .entry_addr (addr_vec),
        .hit        (hit),
        .hit_vec    (hit_vec),
        .hit_idx    (hit_idx)
    );

    logic        store, load, full, load_miss, drain, alloc, coalesce, retire;
    wbuf_entry_t head_entry;

    // Inputs are ignored while reset is held so every output shows its reset value.
    assign store     = cpu_write & reset_n;
    assign load      = cpu_read & ~cpu_write & reset_n;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign load_miss = load & ~hit;
    assign drain     = (count_q != '0) & ~load_miss & reset_n;
    assign coalesce  = store & hit;
    assign alloc     = store & ~hit & ~full;
    // A store that rewrites the draining head must be written again next cycle.
    assign retire    = drain & ~(coalesce & (hit_idx == head_q));

    assign head_entry = entries_q[head_q];

    assign cpu_stall = store & ~hit & full;
    assign buf_empty = (count_q == '0);
    assign mem_read  = load_miss;
    assign mem_write = drain;
    assign mem_addr  = load_miss ? cpu_addr : (drain ? head_entry.addr : '0);
    assign mem_wdata = drain ? head_entry.data : '0;

    always_comb begin
        cpu_rdata = '0;
        if (load) begin
            cpu_rdata = hit ? entries_q[hit_idx].data : mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (coalesce) begin
                entries_q[hit_idx].data <= cpu_wdata;
            end else if (alloc) begin
                entries_q[tail_q] <= '{valid: 1'b1, addr: cpu_addr, data: cpu_wdata};
                tail_q            <= tail_q + PTR_W'(1);
            end
            // alloc and retire never target the same slot: that needs count 0 or full.
            if (retire) begin
                entries_q[head_q].valid <= 1'b0;
                head_q                  <= head_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(alloc) - CNT_W'(retire);
        end
    end
endmodule

// File: tb/tb_dmem_write_buffer.sv
// Bench for dmem_write_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_write_buffer;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_read, cpu_write;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall, buf_empty, mem_read, mem_write;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_write_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (16),
        .DATA_W (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .buf_empty (buf_empty),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // dmemory stand-in: combinational read, write in the clk-low phase.
    logic [15:0] dmem    [65536];
    logic [15:0] ref_mem [65536];
    assign mem_rdata = dmem[mem_addr];
    always @(negedge clk) if (mem_write) dmem[mem_addr] <= mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } ent_t;
    ent_t q[$];

    // Reference model: pending stores in FIFO order, head is q[0].
    always @(negedge clk) begin
        int          hi;
        bit          ld, lmiss, drn, ret;
        logic [15:0] e_rdata, e_maddr, e_mwdata;
        bit          e_stall;
        hi = -1;
        foreach (q[i]) if (q[i].addr == cpu_addr) hi = i;
        if (!reset_n) begin
            q.delete();
            chk("rst_rdata", cpu_rdata, 0);
            chk("rst_stall", cpu_stall, 0);
            chk("rst_empty", buf_empty, 1);
            chk("rst_mem_read", mem_read, 0);
            chk("rst_mem_write", mem_write, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
        end else begin
            ld       = cpu_read && !cpu_write;
            lmiss    = ld && hi < 0;
            drn      = q.size() > 0 && !lmiss;
            e_rdata  = !ld ? 16'h0 : (hi >= 0 ? q[hi].data : ref_mem[cpu_addr]);
            e_maddr  = lmiss ? cpu_addr : (drn ? q[0].addr : 16'h0);
            e_mwdata = drn ? q[0].data : 16'h0;
            e_stall  = cpu_write && hi < 0 && q.size() == DEPTH;
            chk("m_rdata", cpu_rdata, e_rdata);
            chk("m_stall", cpu_stall, e_stall);
            chk("m_empty", buf_empty, q.size() == 0);
            chk("m_mem_read", mem_read, lmiss);
            chk("m_mem_write", mem_write, drn);
            chk("m_mem_addr", mem_addr, e_maddr);
            chk("m_mem_wdata", mem_wdata, e_mwdata);
            ret = drn && !(cpu_write && hi == 0);
            if (cpu_write) begin
                if (hi >= 0) q[hi].data = cpu_wdata;
                else if (q.size() < DEPTH) q.push_back('{addr: cpu_addr, data: cpu_wdata});
            end
            if (ret) begin
                ref_mem[q[0].addr] = q[0].data;
                void'(q.pop_front());
            end
        end
    end

    task automatic drive(input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] d);
        @(posedge clk);
        #1;
        cpu_read  = r;
        cpu_write = w;
        cpu_addr  = a;
        cpu_wdata = d;
        #2;
    endtask

    initial begin
        logic        r, w;
        logic [15:0] a, d;
        int unsigned op;
        for (int i = 0; i < 65536; i++) begin
            dmem[i]    = 16'(i) ^ 16'h3c3c;
            ref_mem[i] = 16'(i) ^ 16'h3c3c;
        end
        reset_n = 1'b0;
        cpu_read = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
        repeat (2) @(posedge clk);
        #3;
        chk("reset_empty", buf_empty, 1);
        chk("reset_mem_write", mem_write, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Store then forwarded load; the load hit lets the drain run the same cycle.
        drive(0, 1, 16'h0010, 16'hAAAA);
        chk("st1_mem_write", mem_write, 0);
        drive(1, 0, 16'h0010, 16'h0);
        chk("fwd_rdata", cpu_rdata, 16'hAAAA);
        chk("fwd_mem_read", mem_read, 0);
        chk("fwd_mem_write", mem_write, 1);
        chk("fwd_mem_addr", mem_addr, 16'h0010);
        drive(0, 0, 16'h0, 16'h0);
        chk("st1_empty", buf_empty, 1);
        chk("st1_dmem", dmem[16'h0010], 16'hAAAA);

        // Second store coalesces into the draining head: head written twice.
        drive(0, 1, 16'h0020, 16'h1111);
        drive(0, 1, 16'h0020, 16'h2222);
        chk("coal_wdata1", mem_wdata, 16'h1111);
        drive(0, 0, 16'h0, 16'h0);
        chk("coal_rewrite", mem_write, 1);
        chk("coal_wdata2", mem_wdata, 16'h2222);
        chk("coal_pending", buf_empty, 0);
        drive(0, 0, 16'h0, 16'h0);
        chk("coal_empty", buf_empty, 1);
        chk("coal_dmem", dmem[16'h0020], 16'h2222);

        // Load miss blocks the drain for one cycle.
        drive(0, 1, 16'h0040, 16'h4444);
        drive(1, 0, 16'h0050, 16'h0);
        chk("miss_mem_read", mem_read, 1);
        chk("miss_mem_write", mem_write, 0);
        chk("miss_mem_addr", mem_addr, 16'h0050);
        chk("miss_rdata", cpu_rdata, 16'h3c6c);
        drive(0, 0, 16'h0, 16'h0);
        chk("resume_mem_write", mem_write, 1);
        chk("resume_mem_addr", mem_addr, 16'h0040);

        // Reset asserted while an entry is draining discards it.
        drive(0, 1, 16'h0060, 16'h0007);
        @(posedge clk);
        #1 cpu_write = 0;
        reset_n = 1'b0;
        #1;
        chk("rstmid_mem_write", mem_write, 0);
        chk("rstmid_mem_addr", mem_addr, 0);
        chk("rstmid_empty", buf_empty, 1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        drive(0, 0, 16'h0, 16'h0);
        chk("rstmid_no_write", mem_write, 0);
        drive(0, 0, 16'h0, 16'h0);
        chk("rstmid_dmem", dmem[16'h0060], 16'h3c5c);

        // Randomized traffic over a small address pool; a stalled store is held.
        r = 0; w = 0; a = 0; d = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!cpu_stall) begin
                op = $urandom_range(0, 99);
                r  = (op < 50) || (op >= 95);
                w  = (op >= 50);
                a  = 16'h0100 + 16'($urandom_range(0, 7));
                d  = 16'($urandom);
            end
            drive(r, w, a, d);
        end
        for (int n = 0; n < 2 * DEPTH; n++) drive(0, 0, 16'h0, 16'h0);
        chk("final_empty", buf_empty, 1);
        for (int i = 0; i < 8; i++) begin
            chk("final_dmem", dmem[16'h0100 + 16'(i)], ref_mem[16'h0100 + 16'(i)]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
